cube_gen: RTL and testbench
===========================

// Module: cube_gen
// PURPOSE
//  Sequential integer cuber: accepts an unsigned W-bit root x and returns x^3.
//  It is the inverse of the cube_root block. It generates operands and golden
//  values for cube_root, and rebuilds a cube from a computed root for round-trip
//  checks. Shift-add datapath, one multiplier bit per clock, valid/ready on both
//  sides.
// PARAMETERS
//  W     4        root width in bits; result width is 3*W
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    root x presented on in_x
//  in_ready   out  1    block can accept a root (high only in IDLE)
//  in_x       in   W    unsigned root
//  out_valid  out  1    out_cube/out_sat hold a finished result
//  out_ready  in   1    consumer takes the result
//  out_cube   out  3*W  x^3 (saturated form when CUBE_SAT_EN is defined)
//  out_sat    out  1    result was clamped (always 0 without CUBE_SAT_EN)
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; in_ready=1; out_valid=0; out_cube=0;
//    out_sat=0; all internal registers cleared. Takes effect immediately and
//    applies from any state. An operation in flight is discarded with no output.
//  - States IDLE -> SQ -> CU -> DONE -> IDLE.
//  - IDLE: in_ready=1. A clock edge with in_valid=1 captures x into a W-bit
//    multiplier register and into the x-copy register, clears acc, sets
//    bit counter cnt=0, and moves to SQ.
//  - SQ: W edges. Each edge: if mult[0] then acc += (x << cnt); mult >>= 1;
//    cnt++. After the W-th edge sq=acc (2W bits). Reload mult=x, clear acc,
//    cnt=0, move to CU.
//  - CU: W edges. Same step with addend (sq << cnt), acc 3W bits wide.
//    After the W-th edge register the result into out_cube and move to DONE.
//  - No intermediate value can overflow its register width: x*x < 2^(2W) and
//    x^3 < 2^(3W).
//  - DONE: out_valid=1. out_cube/out_sat stay stable until the handshake
//    out_valid&&out_ready, then the block returns to IDLE (out_valid=0).
//    in_ready is 0 in DONE, so no new root is accepted in the same cycle as the
//    result handshake.
//  - Latency: out_valid rises exactly 2*W edges after the capture edge (8 for
//    W=4). Throughput: at most one root per 2*W+2 cycles.
//  - in_x and in_valid are ignored outside IDLE. out_ready is ignored outside
//    DONE.
//  - out_cube keeps its last value after the handshake. It is only meaningful
//    while out_valid=1.
// CONFIGURATION
//  CUBE_SAT_EN defined:
//    - The result is clamped to the 8-bit input range of cube_root
//      (0..255, zero-extended to 3*W bits).
//    - If x^3 > 255: out_cube=255 and out_sat=1. Otherwise out_sat=0.
//  CUBE_SAT_EN undefined:
//    - out_cube carries the full x^3.
//    - out_sat is tied to 0.
//  Latency and handshake are identical in both builds.
// TESTING
//  1. Assert rst; reset=1 -> in_ready=1, out_valid=0, out_cube=0,
//     out_sat=0 immediately, without waiting for a clock edge.
//  2. W=4, x=3, out_ready=1 -> out_valid high 8 edges after capture,
//     out_cube=27, out_sat=0; back in IDLE the next edge.
//  3. x=0, then x=1 back-to-back -> out_cube=0, then out_cube=1;
//     in_ready stays low throughout SQ/CU/DONE.
//  4. x=15, no CUBE_SAT_EN -> out_cube=3375, out_sat=0.
//     With CUBE_SAT_EN: x=6 -> 216, out_sat=0; x=7 -> 255, out_sat=1;
//     x=15 -> 255, out_sat=1.
//  5. x=5 with out_ready=0 for 10 cycles after DONE -> out_cube holds 125 and
//     out_valid holds 1. A new in_valid during DONE is not captured. Raising
//     out_ready completes the handshake, then IDLE.
//  6. Assert rst in cycle 3 of CU with x=4 -> out_valid stays 0 and
//     in_ready=1 immediately. A new x=2 afterwards yields 8.

Source files
------------

// File: rtl/cube_gen.sv
// Sequential shift-add cuber: x^3 via two W-step multiply passes (x*x, then sq*x).
// Optional build macro CUBE_SAT_EN clamps the result to 0..255 and flags out_sat.
//
//  state | meaning
//  IDLE  | waiting for a root, in_ready=1
//  SQ    | W shift-add steps computing sq = x*x
//  CU    | W shift-add steps computing cube = sq*x
//  DONE  | result held on out_cube/out_sat until out_ready
module cube_gen #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [3*W-1:0] out_cube,
    output logic           out_sat
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        CU   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [W-1:0]    xr;
    logic [W-1:0]    mult;
    logic [2*W-1:0]  sq;
    logic [3*W-1:0]  acc;
    logic [CW-1:0]   cnt;

    logic [3*W-1:0]  addend;
    logic [3*W-1:0]  acc_sum;
    logic            last_step;

    // The square pass shifts x, the cube pass shifts the captured square.
    always_comb begin
        addend = '0;
        if (state == SQ) begin
            addend = {{W{1'b0}}, ({{W{1'b0}}, xr} << cnt)};
        end else begin
            addend = {{W{1'b0}}, sq} << cnt;
        end
        acc_sum   = mult[0] ? (acc + addend) : acc;
        last_step = (cnt == CNT_LAST);
    end

`ifdef CUBE_SAT_EN
    localparam logic [3*W-1:0] SAT_MAX = (3*W)'(255);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_cube  <= '0;
            out_sat   <= 1'b0;
            xr        <= '0;
            mult      <= '0;
            sq        <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr       <= in_x;
                        mult     <= in_x;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SQ;
                    end
                end

                SQ: begin
                    mult <= mult >> 1;
                    cnt  <= cnt + 1'b1;
                    acc  <= acc_sum;
                    if (last_step) begin
                        sq    <= acc_sum[2*W-1:0];
                        mult  <= xr;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CU;
                    end
                end

                CU: begin
                    mult <= mult >> 1;
                    cnt  <= cnt + 1'b1;
                    acc  <= acc_sum;
                    if (last_step) begin
                        cnt       <= '0;
`ifdef CUBE_SAT_EN
                        if (acc_sum > SAT_MAX) begin
                            out_cube <= SAT_MAX;
                            out_sat  <= 1'b1;
                        end else begin
                            out_cube <= acc_sum;
                            out_sat  <= 1'b0;
                        end
`else
                        out_cube  <= acc_sum;
                        out_sat   <= 1'b0;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    // in_ready stays low here so a root is never taken on the handshake edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cube_gen.sv
// Directed bench for cube_gen (W=4): scoreboard of expected cubes, immediate-assertion checks.
module tb_cube_gen;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic           out_valid;
    logic           out_ready;
    logic [3*W-1:0] out_cube;
    logic           out_sat;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3*W-1:0] cube;
        logic           sat;
    } exp_t;

    exp_t sb[$];

    cube_gen #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cube  (out_cube),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int x);
        exp_t e;
        int   c;
        c = x * x * x;
`ifdef CUBE_SAT_EN
        if (c > 255) begin
            e.cube = 12'd255;
            e.sat  = 1'b1;
        end else begin
            e.cube = c[3*W-1:0];
            e.sat  = 1'b0;
        end
`else
        e.cube = c[3*W-1:0];
        e.sat  = 1'b0;
`endif
        return e;
    endfunction

    // Issue one root, check busy/latency/result, optionally stall the consumer.
    task automatic run_op(input int x, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_x     = W'(x);
        in_valid = 1'b1;
        sb.push_back(model(x));
        step();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            step();
            n++;
        end
        check("latency", 32'(n), 32'(2 * W));
        e = sb.pop_front();
        check("out_cube", 32'(out_cube), 32'(e.cube));
        check("out_sat", 32'(out_sat), 32'(e.sat));
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                in_x     = W'(9);
                in_valid = 1'b1;
            end
            if (i == 5) in_valid = 1'b0;
            step();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_cube", 32'(out_cube), 32'(e.cube));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_ready", 32'(in_ready), 32'd1);
        check("post_hs_cube_kept", 32'(out_cube), 32'(e.cube));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_cube", 32'(out_cube), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        run_op(3, 0);
        run_op(0, 0);
        run_op(1, 0);
        run_op(15, 0);
        run_op(6, 0);
        run_op(7, 0);
        run_op(5, 10);
        step();
        check("idle_after_stall", 32'(in_ready), 32'd1);

        // Abort a root mid-flight in the third CU cycle.
        in_x     = W'(4);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (W + 2) step();
        check("abort_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_cube", 32'(out_cube), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("abort_no_output", 32'(out_valid), 32'd0);
        end
        run_op(2, 0);

        for (int i = 0; i < 4; i++) run_op(int'($urandom_range(0, 15)), i);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
